// File: rtl/multi_port_regfile_pkg.sv
// regfile_pkg: shared FSM state type, default widths and packed-slice helper for multi_port_regfile.
package regfile_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int NUM_RD_DEF = 2;
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/multi_port_regfile_if.sv
// multi_port_regfile_if: write port, packed read ports and clear control of the register file.
interface multi_port_regfile_if import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);
  logic                     we;
  logic [ADDR_W-1:0]        addr_wr;
  logic [DATA_W-1:0]        data_in;
  logic [NUM_RD*ADDR_W-1:0] addr_rd;
  logic [NUM_RD*DATA_W-1:0] data_rd;
  logic                     init_req;
  logic                     busy;
  modport master (output we, addr_wr, data_in, addr_rd, init_req, input data_rd, busy);
  modport slave (input we, addr_wr, data_in, addr_rd, init_req, output data_rd, busy);
endinterface

// File: rtl/multi_port_regfile_bank.sv
// regfile_bank: one storage copy with a single registered read port.
// REGFILE_BYPASS_EN selects write-first read-during-write; otherwise read-first.
module regfile_bank import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              mem_we, rd_zero;
  always_comb begin
    mem_we  = we && !(ZERO_REG != 0 && waddr == '0);
    rd_zero = clr || (ZERO_REG != 0 && raddr == '0);
`ifdef REGFILE_BYPASS_EN
    rdata_d = rd_zero ? '0 : (we && raddr == waddr) ? wdata : mem_q[raddr];
`else
    rdata_d = rd_zero ? '0 : mem_q[raddr];
`endif
  end
  always_ff @(posedge clk)
    if (mem_we) mem_q[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/multi_port_regfile.sv
// multi_port_regfile: one write port, NUM_RD registered read ports, hardware clear sweep.
// Optional macro REGFILE_BYPASS_EN makes reads write-first.
module multi_port_regfile import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input logic                clk,
  input logic                rst_n,
  multi_port_regfile_if.slave bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr, bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d   = cnt_q + ADDR_W'(1);
      state_d = &cnt_q ? ST_READY : ST_CLEAR;
    end else if (bus.init_req) begin
      cnt_d   = '0;
      state_d = ST_CLEAR;
    end
  end
  // The sweep hijacks the write port; user writes during it are simply dropped.
  always_comb begin
    clr        = state_q == ST_CLEAR;
    bank_we    = clr || bus.we;
    bank_waddr = clr ? cnt_q : bus.addr_wr;
    bank_wdata = clr ? '0 : bus.data_in;
  end
  assign bus.busy = clr;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_bank
    regfile_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .clr   (clr),
      .raddr (bus.addr_rd[slice_lo(k, ADDR_W) +: ADDR_W]),
      .rdata (bus.data_rd[slice_lo(k, DATA_W) +: DATA_W])
    );
  end
endmodule

// File: tb/tb_multi_port_regfile.sv
// tb_multi_port_regfile: directed checks of sweep, read/write, zero register, bypass and reset.
module tb_multi_port_regfile;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  multi_port_regfile_if #(.DATA_W(32), .ADDR_W(8), .NUM_RD(2)) b1 ();
  multi_port_regfile_if #(.DATA_W(32), .ADDR_W(8), .NUM_RD(2)) b2 ();
  multi_port_regfile #(.ZERO_REG(1)) dut (.clk(clk), .rst_n(rst_n), .bus(b1));
  multi_port_regfile #(.ZERO_REG(0)) dut_nz (.clk(clk), .rst_n(rst_n), .bus(b2));
  assign b2.we = b1.we;
  assign b2.addr_wr = b1.addr_wr;
  assign b2.data_in = b1.data_in;
  assign b2.addr_rd = b1.addr_rd;
  assign b2.init_req = b1.init_req;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    b1.we = 1; b1.addr_wr = a; b1.data_in = d;
    tick();
    b1.we = 0;
  endtask

  task automatic test_reset();
    int n;
    logic nz;
    b1.we = 0; b1.addr_wr = 0; b1.data_in = 0; b1.addr_rd = 0; b1.init_req = 0;
    rst_n = 0;
    tick(); tick();
    total++;
    if (b1.busy !== 1'b1 || b1.data_rd !== 64'd0) begin
      bad++; $display("FAIL reset_state busy=%b data_rd=%h exp busy=1 data_rd=0", b1.busy, b1.data_rd);
    end
    rst_n = 1;
    n = 0; nz = 0;
    while (b1.busy === 1'b1 && n < 1000) begin
      tick(); n++;
      if (b1.data_rd !== 64'd0) nz = 1;
    end
    total++;
    if (n !== 256) begin bad++; $display("FAIL reset_sweep_len got=%0d exp=256", n); end
    total++;
    if (nz !== 1'b0) begin bad++; $display("FAIL sweep_reads_zero got=%b exp=0", nz); end
    total++;
    if (b2.busy !== 1'b0) begin bad++; $display("FAIL nz_busy_after_sweep got=%b exp=0", b2.busy); end
    b1.addr_rd = {8'd200, 8'd33};
    tick();
    total++;
    if (b1.data_rd !== 64'd0 || b2.data_rd !== 64'd0) begin
      bad++; $display("FAIL cleared_read got=%h/%h exp=0", b1.data_rd, b2.data_rd);
    end
  endtask

  task automatic test_write_read();
    wr(8'd5, 32'hDEADBEEF);
    b1.addr_rd = {8'd5, 8'd5};
    tick();
    total++;
    if (b1.data_rd !== {2{32'hDEADBEEF}}) begin
      bad++; $display("FAIL same_addr_two_ports got=%h exp=%h", b1.data_rd, {2{32'hDEADBEEF}});
    end
  endtask

  task automatic test_zero_reg();
    wr(8'd0, 32'hFFFFFFFF);
    b1.addr_rd = {8'd0, 8'd0};
    tick();
    total++;
    if (b1.data_rd !== 64'd0) begin bad++; $display("FAIL zero_reg_on got=%h exp=0", b1.data_rd); end
    total++;
    if (b2.data_rd !== {2{32'hFFFFFFFF}}) begin
      bad++; $display("FAIL zero_reg_off got=%h exp=%h", b2.data_rd, {2{32'hFFFFFFFF}});
    end
    b1.we = 1; b1.addr_wr = 0; b1.data_in = 32'h11;
    tick();
    b1.we = 0;
    total++;
    if (b1.data_rd !== 64'd0) begin bad++; $display("FAIL zero_reg_rdw got=%h exp=0", b1.data_rd); end
`ifdef REGFILE_BYPASS_EN
    total++;
    if (b2.data_rd[31:0] !== 32'h11) begin bad++; $display("FAIL nz_rdw got=%h exp=11", b2.data_rd[31:0]); end
`else
    total++;
    if (b2.data_rd[31:0] !== 32'hFFFFFFFF) begin bad++; $display("FAIL nz_rdw got=%h exp=ffffffff", b2.data_rd[31:0]); end
`endif
  endtask

  task automatic test_read_during_write();
    logic [31:0] exp_p1;
    wr(8'd7, 32'hAAAA0000);
    b1.addr_rd = {8'd7, 8'd5};
    b1.we = 1; b1.addr_wr = 7; b1.data_in = 32'h12345678;
    tick();
    b1.we = 0;
`ifdef REGFILE_BYPASS_EN
    exp_p1 = 32'h12345678;
`else
    exp_p1 = 32'hAAAA0000;
`endif
    total++;
    if (b1.data_rd[63:32] !== exp_p1) begin bad++; $display("FAIL rdw_port1 got=%h exp=%h", b1.data_rd[63:32], exp_p1); end
    total++;
    if (b1.data_rd[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rdw_port0 got=%h exp=deadbeef", b1.data_rd[31:0]); end
    tick();
    total++;
    if (b1.data_rd[63:32] !== 32'h12345678) begin bad++; $display("FAIL rdw_next got=%h exp=12345678", b1.data_rd[63:32]); end
  endtask

  task automatic test_init_req();
    int n;
    b1.init_req = 1;
    tick();
    b1.init_req = 0;
    total++;
    if (b1.busy !== 1'b1) begin bad++; $display("FAIL init_busy_rise got=%b exp=1", b1.busy); end
    n = 0;
    while (b1.busy === 1'b1 && n < 1000) begin
      if (n == 10) begin b1.we = 1; b1.addr_wr = 9; b1.data_in = 32'h55; end
      tick(); n++;
      b1.we = 0;
    end
    total++;
    if (n !== 256) begin bad++; $display("FAIL init_sweep_len got=%0d exp=256", n); end
    b1.addr_rd = {8'd7, 8'd5};
    tick();
    total++;
    if (b1.data_rd !== 64'd0) begin bad++; $display("FAIL init_cleared_5_7 got=%h exp=0", b1.data_rd); end
    b1.addr_rd = {8'd9, 8'd9};
    tick();
    total++;
    if (b1.data_rd !== 64'd0 || b2.data_rd !== 64'd0) begin
      bad++; $display("FAIL busy_write_dropped got=%h/%h exp=0", b1.data_rd, b2.data_rd);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    wr(8'd3, 32'hCAFE);
    b1.addr_rd = {8'd3, 8'd3};
    tick();
    total++;
    if (b1.data_rd !== {2{32'hCAFE}}) begin bad++; $display("FAIL ready_read3 got=%h exp=%h", b1.data_rd, {2{32'hCAFE}}); end
    #2 rst_n = 0;
    #1;
    total++;
    if (b1.data_rd !== 64'd0 || b1.busy !== 1'b1) begin
      bad++; $display("FAIL async_reset_ready data_rd=%h busy=%b exp 0/1", b1.data_rd, b1.busy);
    end
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 100; i++) tick();
    rst_n = 0;
    #2;
    total++;
    if (b1.data_rd !== 64'd0 || b1.busy !== 1'b1) begin
      bad++; $display("FAIL async_reset_sweep data_rd=%h busy=%b exp 0/1", b1.data_rd, b1.busy);
    end
    tick(); tick(); tick();
    rst_n = 1;
    n = 0;
    while (b1.busy === 1'b1 && n < 1000) begin
      if (n == 50) b1.init_req = 1;
      tick(); n++;
      b1.init_req = 0;
    end
    total++;
    if (n !== 256) begin bad++; $display("FAIL restart_sweep_len got=%0d exp=256", n); end
    tick();
    total++;
    if (b1.data_rd !== 64'd0 || b1.busy !== 1'b0) begin
      bad++; $display("FAIL after_restart data_rd=%h busy=%b exp 0/0", b1.data_rd, b1.busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_read_during_write();
    test_init_req();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
